// File: rtl/time_bcd_formatter.sv
// Captures hours/minutes/seconds and converts two fields to packed BCD with a
// bit-serial double-dabble engine. Optional 12-hour remap: `TWELVE_HOUR_EN.
module time_bcd_formatter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [4:0]  hours,
    input  logic [5:0]  minutes,
    input  logic [5:0]  seconds,
    output logic [15:0] bcd_data,
    output logic        done,
    output logic        busy,
    output logic        pm
);

    typedef enum logic [1:0] {IDLE, CONV_HI, CONV_LO, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [5:0]  op_hi_q, op_hi_d;
    logic [5:0]  op_lo_q, op_lo_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] bcd_q, bcd_d;
    logic [4:0]  hr_sel;

    function automatic logic [7:0] dd_step(input logic [7:0] v, input logic b);
        logic [7:0] r;
        r = v;
        if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
        if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
        return {r[6:0], b};
    endfunction

`ifdef TWELVE_HOUR_EN
    logic pm_cap_q, pm_cap_d;
    logic pm_q, pm_d;
    logic accept, finish;

    always_comb begin
        hr_sel = hours;
        if (hours == 5'd0)
            hr_sel = 5'd12;
        else if (hours > 5'd12)
            hr_sel = hours - 5'd12;
    end

    assign accept = start && (state_q == IDLE || state_q == DONE);
    assign finish = (state_q == CONV_LO) && (cnt_q == 3'd6);

    // pm follows captured hours regardless of mode; shown only on DONE entry
    always_comb begin
        pm_cap_d = accept ? (hours >= 5'd12) : pm_cap_q;
        pm_d     = finish ? pm_cap_q : pm_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pm_cap_q <= 1'b0;
            pm_q     <= 1'b0;
        end else begin
            pm_cap_q <= pm_cap_d;
            pm_q     <= pm_d;
        end
    end

    assign pm = pm_q;
`else
    assign hr_sel = hours;
    assign pm     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_hi_d = op_hi_q;
        op_lo_d = op_lo_q;
        sh_d    = sh_q;
        hi_d    = hi_q;
        bcd_d   = bcd_q;
        unique case (state_q)
            // DONE accepts a new start directly so a held start repeats every 14 cycles
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    op_hi_d = mode ? minutes : {1'b0, hr_sel};
                    op_lo_d = mode ? seconds : minutes;
                    cnt_d   = '0;
                    sh_d    = '0;
                    state_d = CONV_HI;
                end
            end
            CONV_HI: begin
                sh_d    = dd_step(sh_q, op_hi_q[5]);
                op_hi_d = {op_hi_q[4:0], 1'b0};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd5) begin
                    hi_d    = sh_d;
                    sh_d    = '0;
                    cnt_d   = '0;
                    state_d = CONV_LO;
                end
            end
            CONV_LO: begin
                if (cnt_q == 3'd6) begin
                    bcd_d   = {hi_q, sh_q};
                    state_d = DONE;
                end else begin
                    sh_d    = dd_step(sh_q, op_lo_q[5]);
                    op_lo_d = {op_lo_q[4:0], 1'b0};
                    cnt_d   = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_hi_q <= '0;
            op_lo_q <= '0;
            sh_q    <= '0;
            hi_q    <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_hi_q <= op_hi_d;
            op_lo_q <= op_lo_d;
            sh_q    <= sh_d;
            hi_q    <= hi_d;
            bcd_q   <= bcd_d;
        end
    end

    assign bcd_data = bcd_q;
    assign done     = (state_q == DONE);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_time_bcd_formatter.sv
// Directed bench for time_bcd_formatter; expected values adapt to `TWELVE_HOUR_EN.
module tb_time_bcd_formatter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [4:0]  hours = '0;
    logic [5:0]  minutes = '0;
    logic [5:0]  seconds = '0;
    logic [15:0] bcd_data;
    logic        done;
    logic        busy;
    logic        pm;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] last_bcd = '0;

    time_bcd_formatter dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .hours    (hours),
        .minutes  (minutes),
        .seconds  (seconds),
        .bcd_data (bcd_data),
        .done     (done),
        .busy     (busy),
        .pm       (pm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One conversion from a start pulse; optionally changes inputs before E3.
    task automatic run_conv(input string tag, input logic [4:0] h, input logic [5:0] m,
                            input logic [5:0] s, input logic md, input logic [15:0] exp_bcd,
                            input logic exp_pm, input bit disturb);
        int done_k;
        int busy_n;
        @(negedge clk);
        hours = h; minutes = m; seconds = s; mode = md; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_k = 0;
        busy_n = 0;
        for (int k = 1; k <= 20 && done_k == 0; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (disturb && k == 2) begin
                hours = 5'd1; minutes = 6'd2; seconds = 6'd3;
            end
            if (k == 7) check({tag, "_hold"}, bcd_data, last_bcd);
            if (done) done_k = k;
        end
        check({tag, "_lat"}, done_k, 14);
        check({tag, "_busy"}, busy_n, 14);
        check({tag, "_bcd"}, bcd_data, exp_bcd);
        check({tag, "_pm"}, pm, exp_pm);
        @(negedge clk);
        check({tag, "_done_low"}, done, 0);
        check({tag, "_idle"}, busy, 0);
        last_bcd = exp_bcd;
    endtask

    initial begin
        int done_n;
        int first_k;
        int second_k;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_bcd", bcd_data, 16'h0000);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_pm", pm, 0);

`ifdef TWELVE_HOUR_EN
        run_conv("hhmm", 5'd14, 6'd37, 6'd52, 1'b0, 16'h0237, 1'b1, 0);
        run_conv("mmss", 5'd14, 6'd37, 6'd52, 1'b1, 16'h3752, 1'b1, 1);
`else
        run_conv("hhmm", 5'd14, 6'd37, 6'd52, 1'b0, 16'h1437, 1'b0, 0);
        run_conv("mmss", 5'd14, 6'd37, 6'd52, 1'b1, 16'h3752, 1'b0, 1);
`endif
        run_conv("h0509", 5'd5, 6'd9, 6'd0, 1'b0, 16'h0509, 1'b0, 0);

        // Reset at E8 aborts a 23:59 conversion
        @(negedge clk);
        hours = 5'd23; minutes = 6'd59; mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_bcd", bcd_data, 16'h0000);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        reset = 1'b0;
        done_n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check("abort_no_done", done_n, 0);
        last_bcd = '0;

        // Start re-pulsed at E5 is ignored
        @(negedge clk);
        hours = 5'd5; minutes = 6'd9; seconds = 6'd0; mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_n = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 4) start = 1'b1;
            if (k == 5) start = 1'b0;
            if (done) done_n++;
        end
        check("repulse_count", done_n, 1);
        check("repulse_bcd", bcd_data, 16'h0509);
        last_bcd = 16'h0509;

        // Held start: done pulses 14 cycles apart
        @(negedge clk);
        hours = 5'd14; minutes = 6'd37; seconds = 6'd52; mode = 1'b1; start = 1'b1;
        first_k = 0;
        second_k = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin
                if (first_k == 0) first_k = k;
                else if (second_k == 0) second_k = k;
            end
        end
        start = 1'b0;
        check("held_spacing", second_k - first_k, 14);
        check("held_bcd", bcd_data, 16'h3752);
        repeat (20) @(negedge clk);
        check("held_idle", busy, 0);
        last_bcd = 16'h3752;

`ifdef TWELVE_HOUR_EN
        run_conv("h0005", 5'd0, 6'd5, 6'd0, 1'b0, 16'h1205, 1'b0, 0);
        run_conv("h2359", 5'd23, 6'd59, 6'd0, 1'b0, 16'h1159, 1'b1, 0);
        run_conv("h1200", 5'd12, 6'd0, 6'd0, 1'b0, 16'h1200, 1'b1, 0);
`else
        run_conv("h0005", 5'd0, 6'd5, 6'd0, 1'b0, 16'h0005, 1'b0, 0);
        run_conv("h2359", 5'd23, 6'd59, 6'd0, 1'b0, 16'h2359, 1'b0, 0);
        run_conv("h1200", 5'd12, 6'd0, 6'd0, 1'b0, 16'h1200, 1'b0, 0);
`endif
        run_conv("s63", 5'd0, 6'd0, 6'd63, 1'b1, 16'h0063, 1'b0, 0);
        run_conv("h31", 5'd31, 6'd60, 6'd0, 1'b1, 16'h6000, 1'b1 & (5'd31 >= 5'd12)
`ifndef TWELVE_HOUR_EN
                 & 1'b0
`endif
                 , 0);

        // Reset and start on the same edge: reset wins
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_start_busy", busy, 0);
        check("rst_start_bcd", bcd_data, 16'h0000);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
